im_arbiter: RTL and testbench

IM_ARBITER -- requirements
Module: im_arbiter

---
 rtl/im_arbiter_if.sv | 44 ++++
 rtl/im_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_im_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/im_arbiter_if.sv
// im_arbiter_if: fetch port, loader port and memory-side signals of the instruction-memory arbiter.
// Latency: none (wiring only); timing is defined by the arbiter behind the slave modport.
// Backpressure: requesters hold *_req until the matching *_gnt is seen high.
interface im_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // fetch port
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  // loader port
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0]        l_len;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic              l_done;
  // shared read data
  logic [DATA_W-1:0] rdata;
  // memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_len, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, l_gnt, l_rvalid, l_done, rdata,
    output mem_addr, mem_wdata, mem_rd_en, mem_wr_en
  );

  // requester / memory-model side
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_len, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, l_gnt, l_rvalid, l_done, rdata,
    input  mem_addr, mem_wdata, mem_rd_en, mem_wr_en
  );
endinterface

// File: rtl/im_arbiter.sv
// im_arbiter: shares one instruction memory between a single-word fetch port and a burst loader port.
// Latency: grant is combinational; memory strobe/address/data registered (+1); read data and rvalid at +2.
// Backpressure: requests are held until granted; an accepted burst owns memory for len+1 cycles and stalls fetch.
// Build option: define IM_ARBITER_LDR_PRIO_EN for fixed loader priority (boot load); otherwise round-robin.
module im_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  im_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // burst context captured at acceptance
  logic [7:0]        r_beats_left;
  logic              r_we;
  logic [ADDR_W-1:0] r_baddr;

  // registered memory request and read-return pipeline
  logic              r_mem_rd_en;
  logic              r_mem_wr_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rd_src;
  logic              r_f_rvalid;
  logic              r_l_rvalid;
  logic              r_l_done;

  logic              w_f_gnt_raw;
  logic              w_l_gnt_raw;
  logic              w_f_gnt;
  logic              w_l_gnt;
  logic              w_accept;
  logic              w_last_beat;
  logic              w_beat_we;
  logic [ADDR_W-1:0] w_beat_addr;
  logic              w_ldr_wins;

  // Word address successor with wrap at the top of the memory.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

`ifdef IM_ARBITER_LDR_PRIO_EN
  assign w_ldr_wins = 1'b1;
`else
  logic r_last_l;

  // Remember which port was granted most recently; loader at reset so fetch wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_l <= 1'b1;
    end else if (w_l_gnt) begin
      r_last_l <= 1'b1;
    end else if (w_f_gnt) begin
      r_last_l <= 1'b0;
    end
  end

  assign w_ldr_wins = ~r_last_l;
`endif

  // Next state and grant decode; IDLE and FETCH arbitrate identically, BURST grants the loader every cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_f_gnt_raw = 1'b0;
    w_l_gnt_raw = 1'b0;
    w_accept    = 1'b0;
    w_last_beat = 1'b0;
    w_beat_we   = r_we;
    w_beat_addr = r_baddr;
    case (r_state)
      BURST: begin
        w_l_gnt_raw = 1'b1;
        w_last_beat = (r_beats_left == 8'd1);
        if (w_last_beat) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        if (bus.l_req && (!bus.f_req || w_ldr_wins)) begin
          w_l_gnt_raw = 1'b1;
          w_accept    = 1'b1;
          w_beat_we   = bus.l_we;
          w_beat_addr = bus.l_addr;
          w_last_beat = (bus.l_len == 8'd0);
          w_state_nxt = w_last_beat ? IDLE : BURST;
        end else if (bus.f_req) begin
          w_f_gnt_raw = 1'b1;
          w_state_nxt = FETCH;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // Grants are forced low for as long as reset is asserted, not just from the next edge.
  assign w_f_gnt = w_f_gnt_raw & rst_n;
  assign w_l_gnt = w_l_gnt_raw & rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Burst bookkeeping: direction and next address latched at acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beats_left <= 8'd0;
      r_we         <= 1'b0;
      r_baddr      <= '0;
    end else if (w_accept) begin
      r_beats_left <= bus.l_len;
      r_we         <= bus.l_we;
      r_baddr      <= next_addr(bus.l_addr);
    end else if (r_state == BURST) begin
      r_beats_left <= r_beats_left - 8'd1;
      r_baddr      <= next_addr(r_baddr);
    end
  end

  // Register the granted beat onto the memory port and tag reads with their source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rd_en <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd_src    <= 1'b0;
    end else begin
      r_mem_rd_en <= w_f_gnt | (w_l_gnt & ~w_beat_we);
      r_mem_wr_en <= w_l_gnt & w_beat_we;
      r_rd_src    <= w_l_gnt;
      if (w_f_gnt) begin
        r_mem_addr <= bus.f_addr;
      end else if (w_l_gnt) begin
        r_mem_addr <= w_beat_addr;
      end
      if (w_l_gnt && w_beat_we) begin
        r_mem_wdata <= bus.l_wdata;
      end
    end
  end

  // Steer read-valid by the registered source tag; done pulses the cycle after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_rvalid <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_l_done   <= 1'b0;
    end else begin
      r_f_rvalid <= r_mem_rd_en & ~r_rd_src;
      r_l_rvalid <= r_mem_rd_en & r_rd_src;
      r_l_done   <= w_l_gnt & w_last_beat;
    end
  end

  assign bus.f_gnt     = w_f_gnt;
  assign bus.l_gnt     = w_l_gnt;
  assign bus.f_rvalid  = r_f_rvalid;
  assign bus.l_rvalid  = r_l_rvalid;
  assign bus.l_done    = r_l_done;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_rd_en = r_mem_rd_en;
  assign bus.mem_wr_en = r_mem_wr_en;

endmodule

// File: tb/tb_im_arbiter.sv
// tb_im_arbiter: scoreboard bench for im_arbiter with a behavioural memory and reference model.
// Stimulus drives inputs on the falling edge and predicts grants; a monitor checks registered outputs.
module tb_im_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16384;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  im_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  im_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        src;    // 1 = loader
    int          stamp;
  } op_t;

  typedef struct {
    logic        src;
    logic [15:0] data;
    int          stamp;
  } rd_t;

  op_t  op_q[$];
  rd_t  rd_q[$];
  int   done_q[$];

  logic [15:0] env_mem [DEPTH];
  logic [15:0] ref_mem [DEPTH];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  int burst_left = 0;
  bit last_l = 1'b1;
  bit b_we = 1'b0;
  int b_next = 0;
  bit g_f, g_l;

  function automatic logic [15:0] init_word(input int i);
    return 16'((i * 37) ^ 16'hA5C3);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory behind the arbiter: synchronous write, read data one cycle after the strobe.
  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = init_word(i);
    env_mem[16'h0010] = 16'hBEEF;
    forever begin
      @(posedge clk);
      if (bus.mem_wr_en) env_mem[bus.mem_addr[13:0]] = bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= env_mem[bus.mem_addr[13:0]];
    end
  end

  // One cycle: apply inputs, predict and compare grants, queue what the grants must produce.
  task automatic step(input bit fr, input int fa, input bit lr, input bit lw,
                      input int la, input int ll, input int lwd);
    bit ef, el, ldr_first;
    int a;
    op_t o;
    @(negedge clk);
    bus.f_req   = fr;
    bus.f_addr  = 16'(fa);
    bus.l_req   = lr;
    bus.l_we    = lw;
    bus.l_addr  = 16'(la);
    bus.l_len   = 8'(ll);
    bus.l_wdata = 16'(lwd);
    #1;
`ifdef IM_ARBITER_LDR_PRIO_EN
    ldr_first = 1'b1;
`else
    ldr_first = !last_l;
`endif
    if (burst_left > 0) begin
      ef = 1'b0;
      el = 1'b1;
    end else begin
      el = lr && (!fr || ldr_first);
      ef = fr && !el;
    end
    check("grant", {bus.f_gnt, bus.l_gnt}, {ef, el});
    g_f = ef;
    g_l = el;
    if (ef) begin
      o.we = 1'b0; o.addr = 16'(fa); o.wdata = 16'h0; o.src = 1'b0; o.stamp = cyc + 1;
      op_q.push_back(o);
      last_l = 1'b0;
    end
    if (el) begin
      if (burst_left == 0) begin
        b_we = lw;
        a = la % DEPTH;
        burst_left = ll;
      end else begin
        a = b_next;
        burst_left--;
      end
      b_next = (a + 1) % DEPTH;
      o.we = b_we; o.addr = 16'(a); o.wdata = b_we ? 16'(lwd) : 16'h0; o.src = 1'b1; o.stamp = cyc + 1;
      op_q.push_back(o);
      if (burst_left == 0) done_q.push_back(cyc + 1);
      last_l = 1'b1;
    end
  endtask

  task automatic run_fetch(input int fa);
    bit fp;
    fp = 1'b1;
    for (int k = 0; k < 8 && fp; k++) begin
      step(fp, fa, 1'b0, 1'b0, 0, 0, 0);
      if (g_f) fp = 1'b0;
    end
    check("fetch_granted", fp, 1'b0);
  endtask

  // Loader burst; optionally a fetch request is raised right after acceptance and held until granted.
  task automatic run_burst(input bit we, input int addr, input int len, input bit with_f, input int fa);
    bit acc, fp;
    int k;
    acc = 1'b0; fp = 1'b0; k = 0;
    while ((!acc || burst_left > 0 || fp) && k < len + 16) begin
      step(fp, fa, !acc, acc ? 1'($urandom % 2) : we, acc ? int'($urandom % 65536) : addr,
           acc ? int'($urandom % 256) : len, int'($urandom % 65536));
      if (g_f) fp = 1'b0;
      if (g_l && !acc) begin
        acc = 1'b1;
        fp = with_f;
      end
      k++;
    end
    check("burst_complete", {acc, fp}, 2'b10);
  endtask

  function automatic logic [63:0] reset_view();
    return {bus.f_gnt, bus.l_gnt, bus.f_rvalid, bus.l_rvalid, bus.l_done,
            bus.mem_rd_en, bus.mem_wr_en, bus.mem_addr, bus.mem_wdata};
  endfunction

  task automatic clear_model();
    op_q.delete();
    rd_q.delete();
    done_q.delete();
    burst_left = 0;
    last_l = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a memory strobe, read data or done.
  initial begin : monitor
    op_t o;
    rd_t r;
    logic [15:0] wd;
    forever begin
      @(negedge clk);
      check("rvalid_exclusive", bus.f_rvalid & bus.l_rvalid, 1'b0);
      check("strobe_exclusive", bus.mem_rd_en & bus.mem_wr_en, 1'b0);
      if (bus.mem_rd_en || bus.mem_wr_en) begin
        if (op_q.size() == 0) begin
          fail_now("mem_op_unexpected", int'(bus.mem_addr), -1);
        end else begin
          o = op_q.pop_front();
          wd = bus.mem_wr_en ? bus.mem_wdata : 16'h0;
          check("mem_op", {bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, wd, 16'(cyc)},
                {o.we, ~o.we, o.addr, o.wdata, 16'(o.stamp)});
          if (o.we) begin
            ref_mem[o.addr[13:0]] = o.wdata;
          end else begin
            r.src = o.src; r.data = ref_mem[o.addr[13:0]]; r.stamp = o.stamp + 1;
            rd_q.push_back(r);
          end
        end
      end else if (op_q.size() > 0 && op_q[0].stamp <= cyc) begin
        o = op_q.pop_front();
        fail_now("mem_op_missing", 0, int'(o.addr));
      end
      if (bus.f_rvalid || bus.l_rvalid) begin
        if (rd_q.size() == 0) begin
          fail_now("rvalid_unexpected", int'(bus.rdata), -1);
        end else begin
          r = rd_q.pop_front();
          check("read_data", {bus.l_rvalid, bus.f_rvalid, bus.rdata, 16'(cyc)},
                {r.src, ~r.src, r.data, 16'(r.stamp)});
        end
      end else if (rd_q.size() > 0 && rd_q[0].stamp <= cyc) begin
        r = rd_q.pop_front();
        fail_now("rvalid_missing", 0, int'(r.data));
      end
      if (bus.l_done) begin
        if (done_q.size() == 0) begin
          fail_now("l_done_unexpected", cyc, -1);
        end else begin
          check("l_done_timing", 64'(cyc), 64'(done_q.pop_front()));
        end
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        fail_now("l_done_missing", 0, done_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bit fp, lp, fr, lr, lw;
    int fa, la, ll;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    ref_mem[16'h0010] = 16'hBEEF;

    // Reset with both requests high: grants and all registered outputs must be low.
    bus.f_req = 1'b1; bus.f_addr = 16'h0; bus.l_req = 1'b1; bus.l_we = 1'b1;
    bus.l_addr = 16'h0; bus.l_len = 8'd3; bus.l_wdata = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", reset_view(), 64'd0);
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Simultaneous requests straight out of reset.
    fp = 1'b1; lp = 1'b1;
    for (int k = 0; k < 4 && (fp || lp); k++) begin
      step(fp, 16'h0020, lp, 1'b1, 16'h0100, 0, 16'h1234);
      if (g_f) fp = 1'b0;
      if (g_l) lp = 1'b0;
    end
    check("contention_served", {fp, lp}, 2'b00);

    // Single fetch of a known word.
    run_fetch(16'h0010);

    // Write burst across the top of memory with fetch waiting throughout.
    run_burst(1'b1, 16'h3FFE, 3, 1'b1, 16'h3FFF);

    // Read burst of two beats followed by a fetch read.
    run_burst(1'b0, 16'h3FFE, 1, 1'b1, 16'h0000);

    // Long write burst aborted by reset after its second beat.
    step(1'b0, 0, 1'b1, 1'b1, 16'h1000, 7, 16'h1111);
    check("abort_burst_accepted", g_l, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 0, 0, 16'h2222);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    clear_model();
    bus.f_req = 1'b1; bus.l_req = 1'b1;
    #1;
    check("reset_mid_burst", reset_view(), 64'd0);
    bus.f_req = 1'b0; bus.l_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    run_fetch(16'h1001);
    run_fetch(16'h1000);

    // Randomised traffic on both ports.
    fr = 1'b0; fa = 0; lr = 1'b0; lw = 1'b0; la = 0; ll = 0;
    for (int n = 0; n < 600; n++) begin
      step(fr, fa, lr, lw, la, ll, int'($urandom % 65536));
      if (fr && !g_f) begin
        if ($urandom % 16 == 0) fr = 1'b0;
      end else begin
        fr = ($urandom % 3) != 0;
        fa = int'($urandom % DEPTH);
      end
      if (burst_left > 0) begin
        lr = 1'b0;
        lw = 1'($urandom % 2);
        la = int'($urandom % 65536);
        ll = int'($urandom % 256);
      end else if (!(lr && !g_l)) begin
        lr = ($urandom % 4) == 0;
        lw = 1'($urandom % 2);
        la = ($urandom % 2 == 0) ? int'(DEPTH - 1 - ($urandom % 4)) : int'($urandom % DEPTH);
        ll = ($urandom % 8 == 0) ? int'($urandom % 40) : int'($urandom % 4);
      end
    end

    // Drain and confirm nothing expected was left undelivered.
    for (int k = 0; k < 8; k++) step(1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
    check("op_queue_drained", op_q.size(), 0);
    check("read_queue_drained", rd_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
